// File: rtl/key_lock_pkg.sv
// Shared widths, CRC polynomial and FSM encoding for the key loader.
package key_lock_pkg;

    localparam int unsigned XW        = 43;
    localparam int unsigned PW        = 4;
    localparam int unsigned CW        = 8;
    localparam int unsigned KW        = XW + PW;
    localparam int unsigned FRAME_LEN = KW + CW;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [CW-1:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/key_crc8_serial.sv
// Serial CRC-8 LFSR (init 0x00), one bit per enabled cycle; clr wins over en.
module key_crc8_serial
    import key_lock_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [CW-1:0] crc
);

    logic [CW-1:0] crc_q;
    logic [CW-1:0] crc_d;
    logic          fb_c;

    // Next LFSR value: shift left, fold in the polynomial when feedback is set.
    always_comb begin
        crc_d = crc_q;
        fb_c  = crc_q[CW-1] ^ bit_in;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = {crc_q[CW-2:0], 1'b0} ^ (fb_c ? CRC_POLY : CW'(0));
        end
    end

    // LFSR register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/locked_key_loader.sv
// Loads a serial key frame, verifies its CRC and commits it to the key ports.
module locked_key_loader
    import key_lock_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          ser_valid,
    input  logic          ser_data,
    output logic          ser_ready,
    output logic [XW-1:0] key_x,
    output logic [PW-1:0] key_p,
    output logic          key_valid,
    output logic          busy,
    output logic          err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KW-1:0]    shadow_q, shadow_d;
    logic [XW-1:0]    key_x_q, key_x_d;
    logic [PW-1:0]    key_p_q, key_p_d;
    logic             key_valid_q, key_valid_d;
    logic             err_q, err_d;
    logic             ser_ready_q, ser_ready_d;
    logic             busy_q, busy_d;
    logic             accept_c;
    logic             crc_clr_c;
    logic [CW-1:0]    crc_c;

    // ser_ready_q is only high in LOAD, so it alone qualifies a bit transfer.
    assign accept_c = ser_ready_q & ser_valid;

    key_crc8_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (crc_clr_c),
        .en     (accept_c),
        .bit_in (ser_data),
        .crc    (crc_c)
    );

    // Next-state and next-output logic for the load/check/commit sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        key_x_d     = key_x_q;
        key_p_d     = key_p_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;
        crc_clr_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    cnt_d       = '0;
                    shadow_d    = '0;
                    key_x_d     = '0;
                    key_p_d     = '0;
                    key_valid_d = 1'b0;
                    err_d       = 1'b0;
                    crc_clr_c   = 1'b1;
                end
            end
            LOAD: begin
                if (accept_c) begin
                    if (cnt_q < CNT_W'(KW)) begin
                        shadow_d[cnt_q] = ser_data;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                // CRC bits were fed through the LFSR too, so a clean frame leaves zero.
                if (crc_c == '0) begin
                    state_d = COMMIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                key_x_d     = shadow_q[XW-1:0];
                key_p_d     = shadow_q[KW-1:XW];
                key_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ser_ready_d = (state_d == LOAD);
        busy_d      = (state_d == LOAD) || (state_d == CHECK);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            key_x_q     <= '0;
            key_p_q     <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ser_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            key_x_q     <= key_x_d;
            key_p_q     <= key_p_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
            ser_ready_q <= ser_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign ser_ready = ser_ready_q;
    assign key_x     = key_x_q;
    assign key_p     = key_p_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_locked_key_loader.sv
// Directed plus randomized frame loads checked against a polynomial-division model.
module tb_locked_key_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ser_valid;
    logic        ser_data;
    logic        ser_ready;
    logic [42:0] key_x;
    logic [3:0]  key_p;
    logic        key_valid;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    locked_key_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .key_x     (key_x),
        .key_p     (key_p),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of (message * x^8) mod (x^8 + x^2 + x + 1).
    function automatic logic [7:0] crc_ref(input logic [46:0] k);
        logic [8:0] rem;
        rem = '0;
        for (int i = 0; i < 55; i++) begin
            rem = {rem[7:0], (i < 47) ? k[i] : 1'b0};
            if (rem[8]) rem = rem ^ 9'h107;
        end
        return rem[7:0];
    endfunction

    // Frame bit i is the i-th bit on the wire: key LSB first, then CRC MSB first.
    function automatic logic [54:0] make_frame(input logic [46:0] k);
        logic [54:0] fr;
        logic [7:0]  c;
        c = crc_ref(k);
        fr[46:0] = k;
        for (int j = 0; j < 8; j++) fr[47 + j] = c[7 - j];
        return fr;
    endfunction

    task automatic do_start(input string tag, input bit check_clear);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_rdy_after_start"}, 64'(ser_ready), 64'd1);
        chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        if (check_clear) begin
            chk({tag, "_kv_cleared"}, 64'(key_valid), 64'd0);
            chk({tag, "_err_cleared"}, 64'(err), 64'd0);
            chk({tag, "_kx_cleared"}, 64'(key_x), 64'd0);
            chk({tag, "_kp_cleared"}, 64'(key_p), 64'd0);
        end
    endtask

    // Streams bits [0, nbits) of a frame; optionally pulses start when bit start_at is presented.
    task automatic stream(input string tag, input logic [54:0] fr, input bit gaps,
                          input int start_at, input int nbits);
        int idx = 0;
        int cyc = 0;
        bit rdy_ok = 1'b1;
        bit v;
        while (idx < nbits && cyc < 4000) begin
            v         = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ser_valid = v;
            ser_data  = fr[idx];
            start     = (idx == start_at);
            if (ser_ready !== 1'b1 || busy !== 1'b1) rdy_ok = 1'b0;
            tick();
            if (v) idx++;
            cyc++;
        end
        ser_valid = 1'b0;
        start     = 1'b0;
        chk({tag, "_bits_sent"}, 64'(idx), 64'(nbits));
        chk({tag, "_ready_in_load"}, 64'(rdy_ok), 64'd1);
    endtask

    // Called just after the edge that accepted the last frame bit.
    task automatic check_tail(input string tag, input bit pass, input logic [46:0] k);
        chk({tag, "_rdy_in_check"}, 64'(ser_ready), 64'd0);
        chk({tag, "_busy_in_check"}, 64'(busy), 64'd1);
        chk({tag, "_kv_in_check"}, 64'(key_valid), 64'd0);
        tick();
        chk({tag, "_busy_after_check"}, 64'(busy), 64'd0);
        chk({tag, "_err_after_check"}, 64'(err), pass ? 64'd0 : 64'd1);
        chk({tag, "_kv_not_early"}, 64'(key_valid), 64'd0);
        tick();
        chk({tag, "_kv"}, 64'(key_valid), pass ? 64'd1 : 64'd0);
        chk({tag, "_err"}, 64'(err), pass ? 64'd0 : 64'd1);
        chk({tag, "_kx"}, 64'(key_x), pass ? 64'(k[42:0]) : 64'd0);
        chk({tag, "_kp"}, 64'(key_p), pass ? 64'(k[46:43]) : 64'd0);
        chk({tag, "_rdy_idle"}, 64'(ser_ready), 64'd0);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rdy"}, 64'(ser_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_kv"}, 64'(key_valid), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_kx"}, 64'(key_x), 64'd0);
        chk({tag, "_kp"}, 64'(key_p), 64'd0);
    endtask

    initial begin
        logic [46:0] k;
        logic [54:0] fr;
        logic [63:0] r;
        bit          flip;
        int          pos;

        rst_n     = 1'b0;
        start     = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();
        check_reset_values("idle");

        // All-zero key, gapless.
        k  = '0;
        fr = make_frame(k);
        do_start("zero", 1'b1);
        stream("zero", fr, 1'b0, -1, 55);
        check_tail("zero", 1'b1, k);

        // key_x = 1, key_p = 4'hA; next start must wipe the committed key at once.
        k  = {4'hA, 43'h1};
        fr = make_frame(k);
        do_start("dir", 1'b1);
        stream("dir", fr, 1'b0, -1, 55);
        check_tail("dir", 1'b1, k);

        // Same frame, CRC LSB flipped.
        fr[54] = ~fr[54];
        do_start("badcrc", 1'b1);
        stream("badcrc", fr, 1'b0, -1, 55);
        check_tail("badcrc", 1'b0, k);
        do_start("err_clear", 1'b1);
        fr[54] = ~fr[54];
        stream("gap", fr, 1'b1, -1, 55);
        check_tail("gap", 1'b1, k);

        // start mid-load is ignored.
        r  = {$urandom(), $urandom()};
        k  = r[46:0];
        fr = make_frame(k);
        do_start("midstart", 1'b1);
        stream("midstart", fr, 1'b0, 20, 55);
        check_tail("midstart", 1'b1, k);

        // Reset while a key is held.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_values("rst_idle");

        // Reset at bit 30, then a full frame.
        do_start("midrst", 1'b1);
        stream("midrst", fr, 1'b0, -1, 30);
        rst_n     = 1'b0;
        ser_valid = 1'b1;
        tick();
        check_reset_values("midrst_after");
        rst_n     = 1'b1;
        ser_valid = 1'b0;
        tick();
        check_reset_values("midrst_idle");
        do_start("postrst", 1'b1);
        stream("postrst", fr, 1'b0, -1, 55);
        check_tail("postrst", 1'b1, k);

        // Random keys, random gaps, occasional single-bit corruption anywhere in the frame.
        for (int n = 0; n < 8; n++) begin
            r    = {$urandom(), $urandom()};
            k    = r[46:0];
            fr   = make_frame(k);
            flip = ($urandom_range(0, 2) == 0);
            if (flip) begin
                pos     = int'($urandom_range(0, 54));
                fr[pos] = ~fr[pos];
            end
            do_start($sformatf("rnd%0d", n), 1'b1);
            stream($sformatf("rnd%0d", n), fr, 1'($urandom_range(0, 1)), -1, 55);
            check_tail($sformatf("rnd%0d", n), !flip, k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/locked_key_loader.md
# locked_key_loader

Key-delivery block for the key-locked c432 netlist. It receives a serialized key frame from secure storage: 43 XOR key bits, 4 mux-select key bits, then an 8-bit CRC. It checks the CRC and then drives the parallel key ports of the locked core. The block sits between the key-store interface and the core's X_1..X_43 / p1..p4 inputs; it is the supplying end of the key port that the locked netlist consumes.

## Interface
Parameters:
- XW, 43, number of XOR key bits (drive X_1..X_XW)
- PW, 4, number of mux key bits (drive p1..pPW)
- CW, 8, checksum width

Ports:
- clk  input  1  single clock, all logic rising-edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse: begin a new frame load
- ser_valid  input  1  serial bit present
- ser_data  input  1  serial key/checksum bit
- ser_ready  output  1  block accepts a bit this cycle
- key_x  output  XW  XOR key bits; key_x[i] drives X_(i+1)
- key_p  output  PW  mux key bits; key_p[i] drives p(i+1)
- key_valid  output  1  key_x/key_p hold a CRC-verified key
- busy  output  1  frame load in progress (LOAD or CHECK)
- err  output  1  last frame failed CRC; sticky until next start

## Operation
- Frame order: key_x[0]..key_x[XW-1], then key_p[0]..key_p[PW-1], then CRC bits MSB first. Total is XW+PW+CW = 55 bits.
- A bit is accepted only when ser_valid && ser_ready.
- The CRC is a serial LFSR with poly 0x07 and init 0x00. For each accepted bit: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 0x07 : 0x00).
- Every accepted bit, including the CRC bits, is fed to the LFSR. The frame passes when the residue is 0x00.
- Incoming key bits are stored in a shadow register. key_x/key_p change only on commit.
- FSM states:
  - IDLE: ser_ready=0. start -> LOAD. Also clears crc, bit counter and err, and forces key_valid=0 and key_x=key_p=0.
  - LOAD: ser_ready=1. The counter counts accepted bits from 0 to 54. On acceptance of bit 54 -> CHECK.
  - CHECK: one cycle, ser_ready=0. Residue 0 -> COMMIT; otherwise err=1 -> IDLE.
  - COMMIT: one cycle. Copies shadow to key_x/key_p, sets key_valid=1, -> IDLE.
- start in LOAD, CHECK or COMMIT is ignored. A frame cannot be aborted except by reset.
- Gaps in ser_valid during LOAD stall the load with no timeout. State is held.
- key_valid stays 1 in IDLE until the next start or reset.

## Timing
- Reset values: ser_ready=0, key_x=0, key_p=0, key_valid=0, busy=0, err=0. State is IDLE, crc=0, counter=0, shadow=0.
- Reset asserted mid-frame takes effect on the next clock edge: all of the above apply and the partial frame is discarded.
- start sampled at edge T: ser_ready=1 and busy=1 from T+1.
- Last bit accepted at edge T: ser_ready=0 from T+1 (CHECK). At T+2 the block is in COMMIT or IDLE with err=1. On pass, key_valid=1 and the key is visible from T+3.
- Minimum frame time is 55 accept cycles plus 3 cycles. Back-to-back streaming is supported.
- busy=1 in LOAD and CHECK, 0 in COMMIT and IDLE.
- err and key_valid are never both 1.

## Structure
- Package key_lock_pkg holds:
  - XW=43, PW=4, CW=8 and FRAME_LEN=55
  - CRC_POLY=8'h07
  - state enum {IDLE, LOAD, CHECK, COMMIT}
- Sub-module key_crc8_serial: clk, rst_n, clr, en, bit_in, crc[7:0]. It contains the LFSR only and is reused by the key-store side to generate frames.
- The top level holds the FSM, bit counter, shadow register and output registers.

## Test plan
- All-zero key with CRC 0x00, bits streamed continuously after start -> key_valid=1 exactly 3 cycles after the last accept, key_x=0, key_p=0, err=0.
- Key key_x=43'h1, key_p=4'hA with CRC from the golden key_crc8_serial -> key_x[0]=1, p2=p4=1, key_valid=1.
- Same frame with the CRC LSB flipped -> err=1, key_valid=0, key_x=key_p=0, block back in IDLE; err clears on the next start.
- Random ser_valid gaps (50% duty) during LOAD -> same committed key as the gapless run; ser_ready stays 1 throughout LOAD.
- start pulsed at bit 20 of an active load -> ignored, frame completes normally; rst_n=0 at bit 30 -> all outputs return to reset values on the next edge, and a following full frame loads correctly.
- Valid key committed, then start -> key_valid=0 and keys zeroed on the next cycle, before any new bits are accepted.
